// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: digit codes,
// controller states and the digit-count helper.
package booth_pkg;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG2,
        NEG1
    } digit_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // One extra digit beyond width/2 absorbs the zero-extended top bits of an
    // unsigned multiplier, so both modes use the same digit loop.
    function automatic int booth_digits(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_digit.sv
// Radix-4 Booth digit: recodes one overlapping multiplier triple and produces
// the matching partial product; negative digits come out inverted plus a carry-in.
module booth_digit
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       i_triple,
    input  logic [WIDTH+1:0] i_mcand,
    output logic [WIDTH+2:0] o_pp,
    output logic             o_neg
);

    digit_t           w_code;
    logic [WIDTH+2:0] w_x1;
    logic [WIDTH+2:0] w_x2;

    assign w_x1 = {i_mcand[WIDTH+1], i_mcand};
    assign w_x2 = {i_mcand, 1'b0};

    always_comb begin
        w_code = ZERO;
        case (i_triple)
            3'b001, 3'b010: w_code = POS1;
            3'b011:         w_code = POS2;
            3'b100:         w_code = NEG2;
            3'b101, 3'b110: w_code = NEG1;
            default:        w_code = ZERO;
        endcase
    end

    always_comb begin
        o_pp  = '0;
        o_neg = 1'b0;
        case (w_code)
            POS1: o_pp = w_x1;
            POS2: o_pp = w_x2;
            NEG2: begin
                o_pp  = ~w_x2;
                o_neg = 1'b1;
            end
            NEG1: begin
                o_pp  = ~w_x1;
                o_neg = 1'b1;
            end
            default: o_pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one digit per clock, signed or unsigned
// per operation, valid/ready on both sides and a held registered product.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z
);

    localparam int N  = booth_digits(WIDTH);
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * WIDTH;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH+1:0] r_mcand;
    logic [WIDTH+2:0] r_mplr;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_z;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH+1:0] w_x_ext;
    logic [WIDTH+1:0] w_y_ext;
    logic [WIDTH+2:0] w_pp;
    logic             w_neg;
    logic [PW-1:0]    w_pp_ext;
    logic [CW:0]      w_shift;
    logic [PW-1:0]    w_addend;
    logic [PW-1:0]    w_cin;
    logic [PW-1:0]    w_acc_next;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == CW'(N - 1));
    assign w_x_ext  = {{2{signed_mode & x[WIDTH-1]}}, x};
    assign w_y_ext  = {{2{signed_mode & y[WIDTH-1]}}, y};

    // r_mplr keeps an implicit zero below the LSB so its low three bits are
    // always the current triple {Y[2i+1], Y[2i], Y[2i-1]}.
    booth_digit #(
        .WIDTH(WIDTH)
    ) u_digit (
        .i_triple(r_mplr[2:0]),
        .i_mcand (r_mcand),
        .o_pp    (w_pp),
        .o_neg   (w_neg)
    );

    assign w_pp_ext   = {{(PW - WIDTH - 3){w_pp[WIDTH+2]}}, w_pp};
    assign w_shift    = {r_cnt, 1'b0};
    assign w_addend   = w_pp_ext << w_shift;
    assign w_cin      = PW'(w_neg) << w_shift;
    assign w_acc_next = r_acc + w_addend + w_cin;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_z     <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_mcand <= w_x_ext;
            r_mplr  <= {w_y_ext, 1'b0};
            r_acc   <= '0;
        end else if (r_state == RUN) begin
            r_acc  <= w_acc_next;
            r_mplr <= {2'b00, r_mplr[WIDTH+2:2]};
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
            // z only changes when a product completes, so it stays put after DONE.
            if (w_last) begin
                r_z <= w_acc_next;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign z         = r_z;

endmodule
